// File: rtl/processor_scheduler.sv
// rtl/processor_scheduler.sv - round-robin scheduler sharing one processor between two requesters
// Holds processor inputs in registers for the whole operation and returns the result on a valid/ready channel.
module processor_scheduler #(
    parameter int DW       = 32,
    parameter int FW       = 16,
    parameter int SW       = 8,
    parameter int PROC_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    input  logic [FW-1:0] req0_flags,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    input  logic [FW-1:0] req1_flags,
    output logic          req1_ready,
    output logic [DW-1:0] proc_data_in,
    output logic [DW-1:0] proc_i_data,
    output logic          proc_data_select,
    output logic [FW-1:0] proc_status_flags,
    input  logic [DW-1:0] proc_data_out,
    input  logic [SW-1:0] proc_status,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic [SW-1:0] rsp_status,
    output logic          busy
);

    localparam int LCW = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rr_ptr;
    logic [LCW-1:0]   r_lat_cnt;
    logic [DW-1:0]    r_proc_data_in;
    logic [DW-1:0]    r_proc_i_data;
    logic             r_proc_sel;
    logic [FW-1:0]    r_proc_flags;
    logic             r_rsp_id;
    logic [DW-1:0]    r_rsp_data;
    logic [SW-1:0]    r_rsp_status;

    logic [1:0]       w_req_valid;
    logic             w_grant_valid;
    logic             w_grant_id;
    logic             w_accept;
    logic             w_rsp_hs;
    logic             w_lat_done;

    assign w_req_valid = {req1_valid, req0_valid};

    // Preferred requester first, otherwise fall back to the other one.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = r_rr_ptr;
        if (w_req_valid[r_rr_ptr]) begin
            w_grant_valid = 1'b1;
            w_grant_id    = r_rr_ptr;
        end else if (w_req_valid[~r_rr_ptr]) begin
            w_grant_valid = 1'b1;
            w_grant_id    = ~r_rr_ptr;
        end
    end

    assign w_accept   = (r_state == S_IDLE) && w_grant_valid && !rst;
    assign w_rsp_hs   = (r_state == S_RESP) && rsp_ready;
    assign w_lat_done = (r_state == S_EXEC) && (r_lat_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_state_nxt = S_EXEC;
            S_EXEC:  if (w_lat_done) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready)  w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr       <= 1'b0;
            r_lat_cnt      <= '0;
            r_proc_data_in <= '0;
            r_proc_i_data  <= '0;
            r_proc_sel     <= 1'b0;
            r_proc_flags   <= '0;
            r_rsp_id       <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_status   <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr       <= ~w_grant_id;
                r_lat_cnt      <= LCW'(PROC_LAT - 1);
                r_proc_sel     <= w_grant_id;
                r_proc_data_in <= w_grant_id ? '0 : req0_data;
                r_proc_i_data  <= w_grant_id ? req1_data : '0;
                r_proc_flags   <= w_grant_id ? req1_flags : req0_flags;
            end
            if (r_state == S_EXEC) begin
                if (w_lat_done) begin
                    r_rsp_id     <= r_proc_sel;
                    r_rsp_data   <= proc_data_out;
                    r_rsp_status <= proc_status;
                end else begin
                    r_lat_cnt <= r_lat_cnt - LCW'(1);
                end
            end
            // Processor inputs idle at zero between operations.
            if (w_rsp_hs) begin
                r_proc_data_in <= '0;
                r_proc_i_data  <= '0;
                r_proc_sel     <= 1'b0;
                r_proc_flags   <= '0;
            end
        end
    end

    assign req0_ready        = w_accept && !w_grant_id;
    assign req1_ready        = w_accept && w_grant_id;
    assign proc_data_in      = r_proc_data_in;
    assign proc_i_data       = r_proc_i_data;
    assign proc_data_select  = r_proc_sel;
    assign proc_status_flags = r_proc_flags;
    assign rsp_valid         = (r_state == S_RESP);
    assign rsp_id            = r_rsp_id;
    assign rsp_data          = r_rsp_data;
    assign rsp_status        = r_rsp_status;
    assign busy              = (r_state != S_IDLE);

endmodule

// File: tb/tb_processor_scheduler.sv
// tb/tb_processor_scheduler.sv - scoreboard bench for processor_scheduler
// Toy processor: select 0 adds flags to data_in, select 1 xors {flags,flags} into i_data.
module tb_processor_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [15:0] req0_flags, req1_flags;
    logic [31:0] proc_data_in, proc_i_data, proc_data_out;
    logic        proc_data_select;
    logic [15:0] proc_status_flags;
    logic [7:0]  proc_status;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_status;

    always #5 clk = ~clk;

    processor_scheduler #(.DW(32), .FW(16), .SW(8), .PROC_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_flags(req0_flags), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_flags(req1_flags), .req1_ready(req1_ready),
        .proc_data_in(proc_data_in), .proc_i_data(proc_i_data), .proc_data_select(proc_data_select),
        .proc_status_flags(proc_status_flags), .proc_data_out(proc_data_out), .proc_status(proc_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .busy(busy)
    );

    assign proc_data_out = proc_data_select ? (proc_i_data ^ {proc_status_flags, proc_status_flags})
                                            : (proc_data_in + {16'h0, proc_status_flags});
    assign proc_status   = {proc_data_select, proc_status_flags[6:0]};

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic [7:0]  st;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_e;
    int          acc_t[$];
    logic        rid_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] e0_data, e1_data;
    logic [7:0]  e0_st, e1_st;
    logic [31:0] hold_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Accept watcher pushes expected results; response monitor pops and compares.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (req0_valid && req0_ready) begin
                exp_q.push_back({1'b0, e0_data, e0_st});
                acc_t.push_back(cyc);
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back({1'b1, e1_data, e1_st});
                acc_t.push_back(cyc);
            end
            if (rsp_valid && rsp_ready) begin
                rid_q.push_back(rsp_id);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got id %0d data %0h expected none", rsp_id, rsp_data);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(m_e.id));
                    chk("rsp_data", 64'(rsp_data), 64'(m_e.data));
                    chk("rsp_status", 64'(rsp_status), 64'(m_e.st));
                end
            end
        end
    end

    task automatic drive_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 64'(k >= 50), 64'(0));
        drive_tick();
    endtask

    task automatic set_contention();
        e0_data = 32'h1111_1112; e0_st = 8'h01;
        e1_data = 32'hA222_A222; e1_st = 8'h80;
        req0_data = 32'h1111_1111; req0_flags = 16'h0001;
        req1_data = 32'h2222_2222; req1_flags = 16'h8000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_data = 0; req1_data = 0; req0_flags = 0; req1_flags = 0;
        e0_data = 0; e1_data = 0; e0_st = 0; e1_st = 0;

        // Reset and single op from requester 0
        repeat (9) drive_tick();
        req0_data = 32'hAAAA_AAAA; req0_flags = 16'hFFFF; req0_valid = 1'b1;
        e0_data = 32'hAAAB_AAA9; e0_st = 8'h7F;
        @(negedge clk);
        chk("rst_ctrl", 64'({req0_ready, req1_ready, rsp_valid, busy, proc_data_select, rsp_id}), 64'(0));
        chk("rst_proc", {proc_data_in, proc_i_data}, 64'(0));
        chk("rst_rsp", {rsp_data, rsp_status, proc_status_flags}, 64'(0));
        drive_tick();
        rst = 1'b0;
        @(negedge clk);
        chk("first_ready", 64'({req0_ready, req1_ready}), 64'(2'b10));
        drive_tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("exec0_ctrl", 64'({proc_data_select, rsp_valid, busy, req0_ready}), 64'(4'b0010));
        chk("exec0_ports", {proc_data_in, proc_i_data}, {32'hAAAA_AAAA, 32'h0});
        chk("exec0_flags", 64'(proc_status_flags), 64'(16'hFFFF));
        @(negedge clk);
        chk("lat_rsp_valid", 64'(rsp_valid), 64'(1));
        @(negedge clk);
        chk("idle_after", 64'({busy, rsp_valid}), 64'(0));
        chk("idle_proc_zero", {proc_data_in, proc_i_data}, 64'(0));
        drain();

        // Contention from reset, then fairness over 8 operations
        rst = 1'b1;
        drive_tick();
        rst = 1'b0;
        acc_t.delete();
        rid_q.delete();
        set_contention();
        @(negedge clk);
        chk("cont_ready0", 64'({req0_ready, req1_ready}), 64'(2'b10));
        @(negedge clk);
        chk("cont_exec0", {proc_data_in, 31'h0, proc_data_select}, {32'h1111_1111, 32'h0});
        @(negedge clk);
        @(negedge clk);
        chk("cont_ready1", 64'({req0_ready, req1_ready}), 64'(2'b01));
        @(negedge clk);
        chk("cont_exec1_sel", 64'(proc_data_select), 64'(1));
        chk("cont_exec1_ports", {proc_data_in, proc_i_data}, {32'h0, 32'h2222_2222});
        chk("cont_exec1_flags", 64'(proc_status_flags), 64'(16'h8000));
        for (int k = 0; k < 60 && acc_t.size() < 8; k++) @(negedge clk);
        chk("fair_accepts", 64'(acc_t.size()), 64'(8));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
        chk("fair_rsp_count", 64'(rid_q.size()), 64'(8));
        for (int i = 0; i < 8 && i < rid_q.size(); i++)
            chk($sformatf("fair_id_%0d", i), 64'(rid_q[i]), 64'(i % 2));
        for (int i = 1; i < 8 && i < acc_t.size(); i++)
            chk($sformatf("fair_gap_%0d", i), 64'(acc_t[i] - acc_t[i-1]), 64'(3));

        // Backpressure, with requester 1 alone granted while rr_ptr prefers 0
        rsp_ready = 1'b0;
        req1_data = 32'h3333_3333; req1_flags = 16'h0F0F; req1_valid = 1'b1;
        e1_data = 32'h3C3C_3C3C; e1_st = 8'h8F;
        @(negedge clk);
        chk("bp_ready1", 64'({req0_ready, req1_ready}), 64'(2'b01));
        drive_tick();
        req1_valid = 1'b0;
        req0_data = 32'h0000_0010; req0_flags = 16'h0005; req0_valid = 1'b1;
        e0_data = 32'h0000_0015; e0_st = 8'h05;
        @(negedge clk);
        chk("bp_exec_noready", 64'({req0_ready, busy}), 64'(2'b01));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_%0d", i), {rsp_data, 23'h0, rsp_valid, rsp_id, req0_ready, req1_ready, rsp_status},
                {32'h3C3C_3C3C, 23'h0, 4'b1100, 8'h8F});
        end
        drive_tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_same_cycle", 64'(req0_ready), 64'(0));
        @(negedge clk);
        chk("bp_next_accept", 64'({busy, req0_ready}), 64'(2'b01));
        drive_tick();
        req0_valid = 1'b0;
        drain();

        // Reset in the middle of EXEC drops the operation
        req1_data = 32'hDDDD_DDDD; req1_flags = 16'hDCBA; req1_valid = 1'b1;
        e1_data = 32'h0167_0167; e1_st = 8'hBA;
        @(negedge clk);
        chk("mid_ready1", 64'(req1_ready), 64'(1));
        drive_tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("mid_in_exec", 64'({busy, proc_data_select}), 64'(2'b11));
        hold_data = proc_i_data;
        chk("mid_exec_idata", 64'(hold_data), 64'(32'hDDDD_DDDD));
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_rst_ctrl", 64'({rsp_valid, busy, proc_data_select, req0_ready, req1_ready}), 64'(0));
        chk("mid_rst_proc", {proc_i_data, proc_data_in}, 64'(0));
        chk("mid_rst_flags", 64'(proc_status_flags), 64'(0));
        drive_tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("mid_no_rsp_%0d", i), 64'({rsp_valid, busy}), 64'(0));
        end
        drive_tick();
        set_contention();
        @(negedge clk);
        chk("mid_rr_reset", 64'({req0_ready, req1_ready}), 64'(2'b10));
        drive_tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
